// File: rtl/rs_issue_select.sv
// rs_issue_select: picks one ready RS entry per cycle into a one-deep ALU issue register,
// tracks ops in flight and turns ALU completions into per-slot broadcast pulses.
// Define RS_ISSUE_RR_EN for round-robin selection (default: fixed priority, lowest index).
package rs_issue_select_pkg;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [OPC_W-1:0]  opcode;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
    } rs_t;

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } sal_t;
endpackage

module rs_issue_select
    import rs_issue_select_pkg::*;
#(
    parameter int unsigned size         = 8,
    parameter int unsigned MAX_INFLIGHT = 2,
    localparam int unsigned IDX_W = (size > 1) ? $clog2(size) : 1,
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  rs_t               rs_data [size],
    input  logic [size-1:0]   rs_ready,
    input  logic              alu_ready,
    input  logic              alu_done,
    input  logic [IDX_W-1:0]  alu_rs_idx,
    input  logic [DATA_W-1:0] alu_result,
    output logic              issue_valid,
    output rs_t               issue_op,
    output logic [IDX_W-1:0]  issue_rs_idx,
    output sal_t              broadcast_bus [size],
    output logic [CNT_W-1:0]  inflight_cnt
);

    logic [size-1:0]  issued;
    logic [TAG_W-1:0] tag_store [size];

    logic [size-1:0]  valid_c;
    logic [size-1:0]  cand_c;
    logic [size-1:0]  grant_mask_c;
    logic [IDX_W-1:0] grant_idx_c;
    logic             grant_c;

    always_comb begin
        for (int unsigned i = 0; i < size; i++) begin
            valid_c[i] = rs_data[i].valid;
            cand_c[i]  = rs_data[i].valid & rs_ready[i] & ~issued[i];
        end
    end

`ifdef RS_ISSUE_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    logic             found_c;

    // First candidate at or after the round-robin pointer, wrapping around.
    always_comb begin
        grant_idx_c = '0;
        found_c     = 1'b0;
        for (int unsigned k = 0; k < size; k++) begin
            if (!found_c && cand_c[IDX_W'((32'(rr_ptr) + k) % size)]) begin
                grant_idx_c = IDX_W'((32'(rr_ptr) + k) % size);
                found_c     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rr_ptr <= '0;
        end else if (grant_c) begin
            rr_ptr <= IDX_W'((32'(grant_idx_c) + 32'd1) % size);
        end
    end
`else
    // Lowest-index candidate wins.
    always_comb begin
        grant_idx_c = '0;
        for (int k = int'(size) - 1; k >= 0; k--) begin
            if (cand_c[k]) begin
                grant_idx_c = IDX_W'(k);
            end
        end
    end
`endif

    always_comb begin
        grant_c      = (|cand_c) && (inflight_cnt < CNT_W'(MAX_INFLIGHT))
                       && (!issue_valid || alu_ready);
        grant_mask_c = grant_c ? (size'(1) << grant_idx_c) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            issue_valid  <= 1'b0;
            issue_op     <= '0;
            issue_rs_idx <= '0;
            issued       <= '0;
            inflight_cnt <= '0;
            for (int unsigned i = 0; i < size; i++) begin
                broadcast_bus[i] <= '0;
                tag_store[i]     <= '0;
            end
        end else begin
            if (grant_c) begin
                issue_valid                <= 1'b1;
                issue_op                   <= rs_data[grant_idx_c];
                issue_rs_idx               <= grant_idx_c;
                tag_store[grant_idx_c]     <= rs_data[grant_idx_c].tag;
            end else if (issue_valid && alu_ready) begin
                issue_valid <= 1'b0;
            end

            // A slot leaving the RS forgets it was issued.
            issued <= (issued & valid_c) | grant_mask_c;

            case ({grant_c, alu_done && (inflight_cnt != '0)})
                2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase

            for (int unsigned i = 0; i < size; i++) begin
                broadcast_bus[i] <= '0;
            end
            if (alu_done) begin
                broadcast_bus[alu_rs_idx] <= '{rdy: 1'b1, tag: tag_store[alu_rs_idx],
                                               data: alu_result};
            end
        end
    end

    // A completion with nothing in flight means the ALU broke protocol.
    always_ff @(posedge clk) begin
        if (!rst && !flush && alu_done) begin
            assert (inflight_cnt != '0);
        end
    end

endmodule

// File: tb/tb_rs_issue_select.sv
// Bench for rs_issue_select: directed scenarios then random traffic, all checked against a
// cycle-level reference model of the selection, in-flight and broadcast rules.
module tb_rs_issue_select;
    import rs_issue_select_pkg::*;

    localparam int SIZE = 8;
    localparam int MAXI = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    rs_t         rs_data [SIZE];
    logic [7:0]  rs_ready;
    logic        alu_ready;
    logic        alu_done;
    logic [2:0]  alu_rs_idx;
    logic [31:0] alu_result;
    logic        issue_valid;
    rs_t         issue_op;
    logic [2:0]  issue_rs_idx;
    sal_t        broadcast_bus [SIZE];
    logic [1:0]  inflight_cnt;

    always #5 clk = ~clk;

    rs_issue_select #(.size(SIZE), .MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .rst(rst), .flush(flush), .rs_data(rs_data), .rs_ready(rs_ready),
        .alu_ready(alu_ready), .alu_done(alu_done), .alu_rs_idx(alu_rs_idx),
        .alu_result(alu_result), .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_rs_idx(issue_rs_idx), .broadcast_bus(broadcast_bus),
        .inflight_cnt(inflight_cnt)
    );

    // Reference model state
    bit          m_issued [SIZE];
    logic [3:0]  m_tag [SIZE];
    bit          m_iv;
    rs_t         m_op;
    int          m_idx;
    int          m_cnt;
    int          m_ptr;
    int          m_bslot;
    logic [3:0]  m_btag;
    logic [31:0] m_bdata;
    int          inflight_q [$];

    int n_cmp;
    int n_bad;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int g;
        int s;
        m_bslot = -1;
        if (rst || flush) begin
            for (int i = 0; i < SIZE; i++) begin
                m_issued[i] = 1'b0;
                m_tag[i]    = '0;
            end
            m_iv = 1'b0; m_op = '0; m_idx = 0; m_cnt = 0; m_ptr = 0;
            inflight_q.delete();
            return;
        end
        g = -1;
        if (m_cnt < MAXI && (!m_iv || alu_ready)) begin
            for (int k = 0; k < SIZE; k++) begin
`ifdef RS_ISSUE_RR_EN
                s = (m_ptr + k) % SIZE;
`else
                s = k;
`endif
                if (g < 0 && rs_data[s].valid && rs_ready[s] && !m_issued[s]) g = s;
            end
        end
        if (alu_done) begin
            m_bslot = int'(alu_rs_idx);
            m_btag  = m_tag[alu_rs_idx];
            m_bdata = alu_result;
            if (m_cnt > 0) m_cnt--;
        end
        for (int i = 0; i < SIZE; i++) begin
            if (!rs_data[i].valid) m_issued[i] = 1'b0;
        end
        if (g >= 0) begin
            m_issued[g] = 1'b1;
            m_tag[g]    = rs_data[g].tag;
            m_iv        = 1'b1;
            m_op        = rs_data[g];
            m_idx       = g;
            m_cnt++;
            m_ptr       = (g + 1) % SIZE;
            inflight_q.push_back(g);
        end else if (m_iv && alu_ready) begin
            m_iv = 1'b0;
        end
    endtask

    task automatic check_all();
        sal_t e;
        chk("issue_valid", 128'(issue_valid), 128'(m_iv));
        chk("issue_rs_idx", 128'(issue_rs_idx), 128'(m_idx));
        chk("issue_op", 128'(issue_op), 128'(m_op));
        chk("inflight_cnt", 128'(inflight_cnt), 128'(m_cnt));
        for (int i = 0; i < SIZE; i++) begin
            e = '0;
            if (i == m_bslot) begin
                e.rdy = 1'b1; e.tag = m_btag; e.data = m_bdata;
            end
            chk($sformatf("broadcast_bus[%0d]", i), 128'(broadcast_bus[i]), 128'(e));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < SIZE; i++) begin
            rs_data[i].valid  = 1'b0;
            rs_data[i].opcode = 4'($urandom);
            rs_data[i].tag    = 4'($urandom);
            rs_data[i].r1     = $urandom;
            rs_data[i].r2     = $urandom;
        end
        rs_ready   = '0;
        alu_ready  = 1'b1;
        alu_done   = 1'b0;
        alu_rs_idx = '0;
        alu_result = '0;
        flush      = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic set_slot(input int s);
        rs_data[s].valid = 1'b1;
        rs_ready[s]      = 1'b1;
    endtask

    // Complete everything still in flight, oldest first, then idle one cycle.
    task automatic drain();
        while (inflight_q.size() > 0) begin
            alu_done   = 1'b1;
            alu_rs_idx = 3'(inflight_q.pop_front());
            alu_result = $urandom;
            cycle();
        end
        alu_done = 1'b0;
        cycle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clear_inputs();

        // Reset held two cycles
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_issue_valid", 128'(issue_valid), 128'(0));
        chk("rst_inflight", 128'(inflight_cnt), 128'(0));

        // Single op on slot 3, completion broadcast
        set_slot(3);
        rs_data[3].tag = 4'hA;
        cycle();
        chk("t2_valid", 128'(issue_valid), 128'(1));
        chk("t2_idx", 128'(issue_rs_idx), 128'(3));
        cycle();
        alu_done   = 1'b1;
        alu_rs_idx = 3'd3;
        alu_result = 32'h55;
        void'(inflight_q.pop_front());
        cycle();
        chk("t2_bcast_rdy", 128'(broadcast_bus[3].rdy), 128'(1));
        chk("t2_bcast_data", 128'(broadcast_bus[3].data), 128'(32'h55));
        chk("t2_bcast_tag", 128'(broadcast_bus[3].tag), 128'(4'hA));
        alu_done = 1'b0;
        rs_data[3].valid = 1'b0;
        cycle();
        chk("t2_pulse_end", 128'(broadcast_bus[3].rdy), 128'(0));

        // In-flight limit: three ready slots, only two granted until a completion
        clear_inputs();
        set_slot(1); set_slot(2); set_slot(5);
        cycle();
        cycle();
        cycle();
        chk("t3_cnt_full", 128'(inflight_cnt), 128'(2));
        chk("t3_stall", 128'(issue_valid), 128'(0));
        alu_done   = 1'b1;
        alu_rs_idx = 3'(inflight_q.pop_front());
        alu_result = $urandom;
        cycle();
        alu_done = 1'b0;
        cycle();
        chk("t3_third", 128'(issue_rs_idx), 128'(5));
        clear_inputs();
        drain();

        // ALU back-pressure: issue register must hold
        clear_inputs();
        set_slot(6);
        cycle();
        alu_ready = 1'b0;
        set_slot(7);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t4_hold_idx", 128'(issue_rs_idx), 128'(6));
        end
        alu_ready = 1'b1;
        cycle();
        clear_inputs();
        drain();

        // Contention between slots 0 and 4, each slot recycled after its grant
        clear_inputs();
        for (int r = 0; r < 4; r++) begin
            set_slot(0); set_slot(4);
            cycle();
            rs_data[m_idx].valid = 1'b0;
            alu_done   = 1'b1;
            alu_rs_idx = 3'(inflight_q.pop_front());
            alu_result = $urandom;
            cycle();
            alu_done = 1'b0;
        end
        clear_inputs();
        drain();

        // Flush with two ops in flight and a completion in the same cycle
        clear_inputs();
        set_slot(2); set_slot(6);
        cycle();
        cycle();
        chk("t6_pre_cnt", 128'(inflight_cnt), 128'(2));
        flush      = 1'b1;
        alu_done   = 1'b1;
        alu_rs_idx = 3'd2;
        alu_result = 32'hDEAD;
        cycle();
        chk("t6_cnt", 128'(inflight_cnt), 128'(0));
        chk("t6_bcast", 128'(broadcast_bus[2].rdy), 128'(0));
        clear_inputs();
        cycle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            int k;
            for (int i = 0; i < SIZE; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rs_data[i].valid  = ($urandom_range(0, 3) != 0);
                    rs_data[i].opcode = 4'($urandom);
                    rs_data[i].tag    = 4'($urandom);
                    rs_data[i].r1     = $urandom;
                    rs_data[i].r2     = $urandom;
                end
                rs_ready[i] = ($urandom_range(0, 2) != 0);
            end
            alu_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            alu_done  = 1'b0;
            if (inflight_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, inflight_q.size() - 1);
                alu_done   = 1'b1;
                alu_rs_idx = 3'(inflight_q[k]);
                alu_result = $urandom;
                inflight_q.delete(k);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
